// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bundle: PC stage inputs, instruction-memory read port and decode handshake.
// master = fetch queue side, slave = surrounding pipeline / memory side.
interface instr_fetch_queue_if #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0] pc;
  logic            flush;
  logic [PC_W-3:0] imem_addr;
  logic            imem_en;
  logic [31:0]     imem_rdata;
  logic            pc_stall;
  logic [31:0]     instr_out;
  logic [PC_W-1:0] pc_out;
  logic            misaligned_out;
  logic            valid_out;
  logic            ready_in;
  logic [CW-1:0]   fill_level;

  modport master (
    input  pc, flush, imem_rdata, ready_in,
    output imem_addr, imem_en, pc_stall, instr_out, pc_out,
           misaligned_out, valid_out, fill_level
  );

  modport slave (
    output pc, flush, imem_rdata, ready_in,
    input  imem_addr, imem_en, pc_stall, instr_out, pc_out,
           misaligned_out, valid_out, fill_level
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: issues word reads for the current PC and buffers the
// returned words, tagged with their PC, in a small FIFO feeding decode.
module instr_fetch_queue #(
  parameter int          PC_W      = 10,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_queue_if.master   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic            mis;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight_mis;

  logic            valid;
  logic            pop;
  logic            issue;
  logic [CW:0]     occupancy;
  entry_t          head;

  assign valid = (count != '0);
  assign pop   = valid && bus.ready_in;
  assign head  = mem[rd_ptr];

  // Slots committed after this edge: queued + returning word - word leaving now.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue     = !reset && !bus.flush && (occupancy < (CW+1)'(DEPTH));

  assign bus.imem_addr = bus.pc[PC_W-1:2];
  assign bus.imem_en   = issue;
  assign bus.pc_stall  = !issue;

  assign bus.valid_out      = valid;
  assign bus.instr_out      = valid ? head.instr : NOP_INSTR;
  assign bus.pc_out         = valid ? head.pc : '0;
  assign bus.misaligned_out = valid && head.mis;
  assign bus.fill_level     = count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      inflight_mis <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc  <= bus.pc;
        inflight_mis <= |bus.pc[1:0];
      end
      if (inflight) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({inflight, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates every read,
  // so stale contents are never visible and the array can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (inflight && !reset && !bus.flush) begin
      mem[wr_ptr] <= '{instr: (inflight_mis ? NOP_INSTR : bus.imem_rdata),
                       pc:    inflight_pc,
                       mis:   inflight_mis};
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_instr_fetch_queue;
  localparam int          PC_W  = 10;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  instr_fetch_queue_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  instr_fetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: word = 0xA0 + word address, garbage when not read.
  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] byte_pc);
    return 32'h0000_00A0 + 32'(byte_pc[PC_W-1:2]);
  endfunction

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= 32'h0000_00A0 + 32'(bus.imem_addr);
    else             bus.imem_rdata <= $urandom;
  end

  // Reference model: a queue of entries plus one outstanding request.
  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic            mis;
  } ent_t;

  ent_t            q[$];
  bit              m_inflight;
  logic [PC_W-1:0] m_ipc;

  logic            cur_r, cur_f, cur_rdy;
  logic [PC_W-1:0] cur_p;
  logic            exp_valid, exp_en, exp_pop, exp_mis;
  logic [31:0]     exp_instr;
  logic [PC_W-1:0] exp_pc;
  int              exp_fill;

  task automatic step_in(input logic r, input logic f, input logic [PC_W-1:0] p,
                         input logic rdy);
    @(negedge clk);
    reset        = r;
    bus.flush    = f;
    bus.pc       = p;
    bus.ready_in = rdy;
    cur_r = r; cur_f = f; cur_p = p; cur_rdy = rdy;
    #1;
    exp_valid = (q.size() != 0);
    exp_fill  = q.size();
    exp_instr = exp_valid ? q[0].instr : NOP;
    exp_pc    = exp_valid ? q[0].pc : '0;
    exp_mis   = exp_valid ? q[0].mis : 1'b0;
    exp_pop   = exp_valid && rdy;
    exp_en    = !r && !f && ((q.size() + int'(m_inflight) - int'(exp_pop)) < DEPTH);
  endtask

  task automatic step_out();
    ent_t e;
    if (cur_r || cur_f) begin
      q.delete();
      m_inflight = 0;
    end else begin
      if (exp_pop) void'(q.pop_front());
      if (m_inflight) begin
        e.mis   = (m_ipc[1:0] != 2'b00);
        e.instr = e.mis ? NOP : mem_word(m_ipc);
        e.pc    = m_ipc;
        q.push_back(e);
      end
      m_inflight = exp_en;
      m_ipc      = cur_p;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    step_in(1'b1, 1'b0, '0, 1'b0); step_out();
    step_in(1'b1, 1'b0, '0, 1'b0); step_out();
  endtask

  task automatic test_reset();
    do_reset();
    step_in(1'b1, 1'b0, '0, 1'b1);
    checks++; if (bus.imem_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", bus.imem_en); end
    checks++; if (bus.pc_stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", bus.pc_stall); end
    step_out();
    step_in(1'b0, 1'b0, '0, 1'b1);
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
    checks++; if (bus.fill_level !== 2'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", bus.fill_level); end
    checks++; if (bus.instr_out !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", bus.instr_out, NOP); end
    checks++; if (bus.pc_out !== '0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.pc_out); end
    checks++; if (bus.misaligned_out !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b exp=0", bus.misaligned_out); end
    checks++; if (bus.imem_en !== 1'b1) begin failures++; $display("FAIL reset_first_issue got=%b exp=1", bus.imem_en); end
    step_out();
  endtask

  task automatic test_streaming();
    logic [PC_W-1:0] p = '0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step_in(1'b0, 1'b0, p, 1'b1);
      checks++; if (bus.pc_stall !== 1'b0) begin failures++; $display("FAIL stream_stall k=%0d got=%b exp=0", k, bus.pc_stall); end
      checks++; if (bus.imem_addr !== p[PC_W-1:2]) begin failures++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, bus.imem_addr, p[PC_W-1:2]); end
      if (k >= 2) begin
        checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, bus.valid_out); end
        checks++; if (bus.instr_out !== 32'hA0 + 32'(k - 2)) begin failures++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, bus.instr_out, 32'hA0 + 32'(k - 2)); end
        checks++; if (bus.pc_out !== PC_W'(4 * (k - 2))) begin failures++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, bus.pc_out, 4 * (k - 2)); end
      end else begin
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL stream_fill_latency k=%0d got=%b exp=0", k, bus.valid_out); end
      end
      step_out();
      p = p + PC_W'(4);
    end
  endtask

  task automatic test_backpressure();
    logic [PC_W-1:0] p = '0;
    logic [PC_W-1:0] next_pc = '0;
    logic            rdy;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      rdy = !(k >= 3 && k <= 8);
      step_in(1'b0, 1'b0, p, rdy);
      if (k >= 4 && k <= 8) begin
        checks++; if (bus.fill_level !== 2'd2) begin failures++; $display("FAIL bp_fill k=%0d got=%0d exp=2", k, bus.fill_level); end
        checks++; if (bus.pc_stall !== 1'b1) begin failures++; $display("FAIL bp_stall k=%0d got=%b exp=1", k, bus.pc_stall); end
        checks++; if (bus.pc_out !== PC_W'(4)) begin failures++; $display("FAIL bp_hold k=%0d got=%h exp=004", k, bus.pc_out); end
      end
      if (bus.valid_out && rdy) begin
        checks++; if (bus.pc_out !== next_pc) begin failures++; $display("FAIL bp_order got=%h exp=%h", bus.pc_out, next_pc); end
        checks++; if (bus.instr_out !== mem_word(next_pc)) begin failures++; $display("FAIL bp_data got=%h exp=%h", bus.instr_out, mem_word(next_pc)); end
        next_pc = next_pc + PC_W'(4);
      end
      if (exp_en) p = p + PC_W'(4);
      step_out();
    end
    checks++; if (next_pc !== PC_W'(24)) begin failures++; $display("FAIL bp_drained got=%h exp=018", next_pc); end
  endtask

  task automatic test_flush();
    do_reset();
    step_in(1'b0, 1'b0, PC_W'(0), 1'b0); step_out();
    step_in(1'b0, 1'b0, PC_W'(4), 1'b0); step_out();
    step_in(1'b0, 1'b1, PC_W'(10'h40), 1'b0);
    checks++; if (bus.imem_en !== 1'b0) begin failures++; $display("FAIL flush_no_issue got=%b exp=0", bus.imem_en); end
    step_out();
    step_in(1'b0, 1'b0, PC_W'(10'h40), 1'b1);
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.valid_out); end
    checks++; if (bus.fill_level !== 2'd0) begin failures++; $display("FAIL flush_fill got=%0d exp=0", bus.fill_level); end
    checks++; if (bus.imem_en !== 1'b1) begin failures++; $display("FAIL flush_reissue got=%b exp=1", bus.imem_en); end
    step_out();
    step_in(1'b0, 1'b0, PC_W'(10'h44), 1'b1);
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL flush_stale got=%b exp=0 pc=%h", bus.valid_out, bus.pc_out); end
    step_out();
    step_in(1'b0, 1'b0, PC_W'(10'h48), 1'b1);
    checks++; if (bus.pc_out !== PC_W'(10'h40)) begin failures++; $display("FAIL flush_target_pc got=%h exp=040", bus.pc_out); end
    checks++; if (bus.instr_out !== 32'h0000_00B0) begin failures++; $display("FAIL flush_target_instr got=%h exp=000000b0", bus.instr_out); end
    step_out();
    step_in(1'b0, 1'b0, PC_W'(10'h4C), 1'b1);
    checks++; if (bus.pc_out !== PC_W'(10'h44)) begin failures++; $display("FAIL flush_next_pc got=%h exp=044", bus.pc_out); end
    step_out();
  endtask

  task automatic test_misaligned();
    do_reset();
    step_in(1'b0, 1'b0, PC_W'(6), 1'b0);
    checks++; if (bus.imem_addr !== 8'd1) begin failures++; $display("FAIL mis_addr got=%h exp=01", bus.imem_addr); end
    step_out();
    step_in(1'b0, 1'b0, PC_W'(8), 1'b0); step_out();
    step_in(1'b0, 1'b0, PC_W'(8), 1'b0);
    checks++; if (bus.instr_out !== NOP) begin failures++; $display("FAIL mis_instr got=%h exp=%h", bus.instr_out, NOP); end
    checks++; if (bus.misaligned_out !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b exp=1", bus.misaligned_out); end
    checks++; if (bus.pc_out !== PC_W'(6)) begin failures++; $display("FAIL mis_pc got=%h exp=006", bus.pc_out); end
    step_out();
    step_in(1'b0, 1'b0, PC_W'(8), 1'b1); step_out();
    step_in(1'b0, 1'b0, PC_W'(12), 1'b1);
    checks++; if (bus.misaligned_out !== 1'b0) begin failures++; $display("FAIL mis_next_flag got=%b exp=0", bus.misaligned_out); end
    checks++; if (bus.instr_out !== 32'h0000_00A2) begin failures++; $display("FAIL mis_next_instr got=%h exp=000000a2", bus.instr_out); end
    step_out();
  endtask

  task automatic test_push_pop_full();
    int              fill_tbl [5] = '{2, 2, 1, 1, 1};
    int              head_tbl [5] = '{0, 0, 4, 8, 12};
    logic [PC_W-1:0] p = '0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step_in(1'b0, 1'b0, p, k >= 4);
      if (k >= 3) begin
        checks++; if (int'(bus.fill_level) != fill_tbl[k-3]) begin failures++; $display("FAIL pp_fill k=%0d got=%0d exp=%0d", k, bus.fill_level, fill_tbl[k-3]); end
        checks++; if (int'(bus.pc_out) != head_tbl[k-3]) begin failures++; $display("FAIL pp_head k=%0d got=%h exp=%h", k, bus.pc_out, head_tbl[k-3]); end
      end
      if (exp_en) p = p + PC_W'(4);
      step_out();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step_in(1'b0, 1'b0, PC_W'(0), 1'b0); step_out();
    step_in(1'b0, 1'b0, PC_W'(4), 1'b0); step_out();
    step_in(1'b1, 1'b1, PC_W'(8), 1'b1);
    checks++; if (bus.imem_en !== 1'b0) begin failures++; $display("FAIL rmid_en got=%b exp=0", bus.imem_en); end
    step_out();
    step_in(1'b0, 1'b0, PC_W'(10'h80), 1'b1);
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", bus.valid_out); end
    checks++; if (bus.fill_level !== 2'd0) begin failures++; $display("FAIL rmid_fill got=%0d exp=0", bus.fill_level); end
    checks++; if (bus.instr_out !== NOP) begin failures++; $display("FAIL rmid_instr got=%h exp=%h", bus.instr_out, NOP); end
    checks++; if (bus.pc_out !== '0) begin failures++; $display("FAIL rmid_pc got=%h exp=0", bus.pc_out); end
    step_out();
    step_in(1'b0, 1'b0, PC_W'(10'h84), 1'b1); step_out();
    step_in(1'b0, 1'b0, PC_W'(10'h88), 1'b1);
    checks++; if (bus.pc_out !== PC_W'(10'h80)) begin failures++; $display("FAIL rmid_first got=%h exp=080", bus.pc_out); end
    step_out();
  endtask

  task automatic test_random();
    logic [PC_W-1:0] p;
    logic            r, f, rdy;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r   = ($urandom_range(39) == 0);
      f   = ($urandom_range(9) == 0);
      rdy = ($urandom_range(2) != 0);
      p   = PC_W'($urandom);
      if ($urandom_range(3) != 0) p[1:0] = 2'b00;
      step_in(r, f, p, rdy);
      checks++; if (bus.valid_out !== exp_valid) begin failures++; $display("FAIL rnd_valid k=%0d got=%b exp=%b", k, bus.valid_out, exp_valid); end
      checks++; if (int'(bus.fill_level) != exp_fill) begin failures++; $display("FAIL rnd_fill k=%0d got=%0d exp=%0d", k, bus.fill_level, exp_fill); end
      checks++; if (int'(bus.fill_level) > DEPTH) begin failures++; $display("FAIL rnd_overflow k=%0d got=%0d exp<=%0d", k, bus.fill_level, DEPTH); end
      checks++; if (bus.imem_en !== exp_en) begin failures++; $display("FAIL rnd_en k=%0d got=%b exp=%b", k, bus.imem_en, exp_en); end
      checks++; if (bus.pc_stall !== !exp_en) begin failures++; $display("FAIL rnd_stall k=%0d got=%b exp=%b", k, bus.pc_stall, !exp_en); end
      checks++; if (bus.imem_addr !== p[PC_W-1:2]) begin failures++; $display("FAIL rnd_addr k=%0d got=%h exp=%h", k, bus.imem_addr, p[PC_W-1:2]); end
      checks++; if (bus.instr_out !== exp_instr) begin failures++; $display("FAIL rnd_instr k=%0d got=%h exp=%h", k, bus.instr_out, exp_instr); end
      if (exp_valid) begin
        checks++; if (bus.pc_out !== exp_pc) begin failures++; $display("FAIL rnd_pc k=%0d got=%h exp=%h", k, bus.pc_out, exp_pc); end
        checks++; if (bus.misaligned_out !== exp_mis) begin failures++; $display("FAIL rnd_mis k=%0d got=%b exp=%b", k, bus.misaligned_out, exp_mis); end
      end
      step_out();
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.flush    = 1'b0;
    bus.pc       = '0;
    bus.ready_in = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_misaligned();
    test_push_pop_full();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
